// File: rtl/video_timing_gen.sv
// Video raster timing generator with a pixel-fetch handshake.
// The counters walk the full raster. Registered outputs describe the counter
// position one clock after it is seen. fetch_next is combinational so that it
// leads the matching de pixel by exactly one cycle.
module video_timing_gen #(
  parameter int H_RES     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_RES     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int SCALE_X   = 1,
  parameter int SCALE_Y   = 1,
  parameter int CW        = 12
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pixel_valid,
  output logic          fetch_next,
  output logic          line_repeat,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          blank,
  output logic          vblank,
  output logic          frame_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          underflow
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_RES);
  localparam logic [CW-1:0] V_ACT   = CW'(V_RES);
  localparam logic [CW-1:0] H_SS    = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] H_SE    = CW'(H_RES + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS    = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] V_SE    = CW'(V_RES + V_FP + V_SYNC);
  // Scale factors are powers of two, so "mod SCALE" reduces to a mask.
  localparam logic [CW-1:0] SX_MASK = CW'(SCALE_X - 1);
  localparam logic [CW-1:0] SY_MASK = CW'(SCALE_Y - 1);

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, x_q, x_d, y_q, y_d;
  logic de_q, de_d, blank_q, blank_d, vblank_q, vblank_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic frame_start_q, frame_start_d, line_repeat_q, line_repeat_d;
  logic underflow_q, underflow_d;
  logic h_wrap, fetch_area, hs_area, vs_area, rep_line;

  // Next-state for counters and all registered outputs; enable low parks everything at reset values.
  always_comb begin
    h_wrap     = (hcnt_q == H_LAST);
    fetch_area = enable && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    fetch_next = fetch_area && ((hcnt_q & SX_MASK) == '0);
    hs_area    = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
    vs_area    = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
    // Every source line except the last replica of its group gets replayed.
    rep_line   = (vcnt_q < V_ACT) && ((vcnt_q & SY_MASK) != SY_MASK);

    hcnt_d        = '0;
    vcnt_d        = '0;
    x_d           = '0;
    y_d           = '0;
    de_d          = 1'b0;
    blank_d       = 1'b1;
    vblank_d      = 1'b0;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    frame_start_d = 1'b0;
    line_repeat_d = 1'b0;
    underflow_d   = 1'b0;

    if (enable) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + CW'(1);
      vcnt_d = vcnt_q;
      if (h_wrap) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
      end
      x_d           = hcnt_q;
      y_d           = vcnt_q;
      de_d          = fetch_area;
      blank_d       = ~fetch_area;
      vblank_d      = (vcnt_q >= V_ACT);
      hsync_d       = hs_area ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = vs_area ? VSYNC_POL : ~VSYNC_POL;
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
      line_repeat_d = hs_area && rep_line;
      // A starved fetch on the first pixel of a frame must not be lost to the frame clear.
      if (fetch_next && !pixel_valid) begin
        underflow_d = 1'b1;
      end else if (frame_start_d) begin
        underflow_d = 1'b0;
      end else begin
        underflow_d = underflow_q;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      blank_q       <= 1'b1;
      vblank_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      line_repeat_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      blank_q       <= blank_d;
      vblank_q      <= vblank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      line_repeat_q <= line_repeat_d;
      underflow_q   <= underflow_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign blank       = blank_q;
  assign vblank      = vblank_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign line_repeat = line_repeat_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances on a small 16x8 raster
// (plain, 2x2 scaled, inverted sync polarity) checked against a position-based model.
module tb_video_timing_gen;

  localparam int HT = 16;
  localparam int VT = 8;
  localparam int FT = HT * VT;
  localparam int SXA[3] = '{1, 2, 1};
  localparam int SYA[3] = '{1, 2, 1};
  localparam bit HPA[3] = '{1'b0, 1'b0, 1'b1};
  localparam bit VPA[3] = '{1'b0, 1'b0, 1'b1};

  logic clk_pixel, rst_n, enable, pixel_valid;
  logic fn[3], lr[3], hs[3], vs[3], de_o[3], bl[3], vb[3], fs[3], uf[3];
  logic [11:0] xo[3], yo[3];

  typedef struct packed {
    logic fn, de, blank, vblank, hs, vs, fs, lr, uf;
    logic [11:0] x, y;
  } exp_t;

  typedef struct {
    int t;
    bit de, hs, vs, vb, fs, fnb, lrb;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int t = 0;
  bit uf_m[3];
  logic pre_fn[3];
  bit log_on = 0;
  int log_idx = 0;
  bit lg_de[256], lg_hs0[256], lg_vs0[256], lg_vb[256], lg_fs[256];
  bit lg_fnb[256], lg_lrb[256], lg_hs2[256], lg_vs2[256];
  vec_t tbl[16];

  video_timing_gen #(.H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_X(1), .SCALE_Y(1), .CW(12)) u_a (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable), .pixel_valid(pixel_valid),
    .fetch_next(fn[0]), .line_repeat(lr[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de_o[0]),
    .blank(bl[0]), .vblank(vb[0]), .frame_start(fs[0]), .x(xo[0]), .y(yo[0]), .underflow(uf[0]));

  video_timing_gen #(.H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_X(2), .SCALE_Y(2), .CW(12)) u_b (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable), .pixel_valid(pixel_valid),
    .fetch_next(fn[1]), .line_repeat(lr[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de_o[1]),
    .blank(bl[1]), .vblank(vb[1]), .frame_start(fs[1]), .x(xo[1]), .y(yo[1]), .underflow(uf[1]));

  video_timing_gen #(.H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_X(1), .SCALE_Y(1), .CW(12)) u_c (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable), .pixel_valid(pixel_valid),
    .fetch_next(fn[2]), .line_repeat(lr[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de_o[2]),
    .blank(bl[2]), .vblank(vb[2]), .frame_start(fs[2]), .x(xo[2]), .y(yo[2]), .underflow(uf[2]));

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Expected behaviour for raster position t (cycles since frame start) of instance k.
  function automatic exp_t model(int k, bit en, int tp, bit pv, bit uf_in);
    exp_t m;
    int h = tp % HT;
    int v = tp / HT;
    bit fa = en && (h < 8) && (v < 4);
    bit hs_act = en && (h >= 10) && (h < 13);
    bit vs_act = en && (v == 5);
    m.fn     = fa && ((h % SXA[k]) == 0);
    m.de     = fa;
    m.blank  = !fa;
    m.vblank = en && (v >= 4);
    m.hs     = hs_act ? HPA[k] : !HPA[k];
    m.vs     = vs_act ? VPA[k] : !VPA[k];
    m.fs     = en && (tp == 0);
    m.lr     = hs_act && (v < 4) && ((v % SYA[k]) != SYA[k] - 1);
    m.x      = en ? 12'(h) : 12'd0;
    m.y      = en ? 12'(v) : 12'd0;
    if (!en)                 m.uf = 1'b0;
    else if (m.fn && !pv)    m.uf = 1'b1;
    else if (tp == 0)        m.uf = 1'b0;
    else                     m.uf = uf_in;
    return m;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0d time=%0t)", nm, act, exp, t, $time);
    end
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_de[%0d]", k), de_o[k], 0);
      chk($sformatf("rst_blank[%0d]", k), bl[k], 1);
      chk($sformatf("rst_vblank[%0d]", k), vb[k], 0);
      chk($sformatf("rst_fs[%0d]", k), fs[k], 0);
      chk($sformatf("rst_lr[%0d]", k), lr[k], 0);
      chk($sformatf("rst_uf[%0d]", k), uf[k], 0);
      chk($sformatf("rst_x[%0d]", k), xo[k], 0);
      chk($sformatf("rst_y[%0d]", k), yo[k], 0);
      chk($sformatf("rst_hs[%0d]", k), hs[k], !HPA[k]);
      chk($sformatf("rst_vs[%0d]", k), vs[k], !VPA[k]);
    end
  endtask

  // One pixel clock: drive inputs at the falling edge, check fetch_next before the rising edge
  // and the registered outputs just after it.
  task automatic cycle(bit en, bit pv);
    exp_t e[3];
    enable = en;
    pixel_valid = pv;
    #1;
    for (int k = 0; k < 3; k++) begin
      e[k] = model(k, en, t, pv, uf_m[k]);
      pre_fn[k] = fn[k];
      chk($sformatf("fetch_next[%0d]", k), fn[k], e[k].fn);
    end
    @(posedge clk_pixel);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("de[%0d]", k), de_o[k], e[k].de);
      chk($sformatf("blank[%0d]", k), bl[k], e[k].blank);
      chk($sformatf("vblank[%0d]", k), vb[k], e[k].vblank);
      chk($sformatf("hsync[%0d]", k), hs[k], e[k].hs);
      chk($sformatf("vsync[%0d]", k), vs[k], e[k].vs);
      chk($sformatf("frame_start[%0d]", k), fs[k], e[k].fs);
      chk($sformatf("line_repeat[%0d]", k), lr[k], e[k].lr);
      chk($sformatf("underflow[%0d]", k), uf[k], e[k].uf);
      chk($sformatf("x[%0d]", k), xo[k], e[k].x);
      chk($sformatf("y[%0d]", k), yo[k], e[k].y);
      uf_m[k] = e[k].uf;
    end
    if (log_on && log_idx < 256) begin
      lg_de[log_idx]  = de_o[0];
      lg_hs0[log_idx] = hs[0];
      lg_vs0[log_idx] = vs[0];
      lg_vb[log_idx]  = vb[0];
      lg_fs[log_idx]  = fs[0];
      lg_fnb[log_idx] = pre_fn[1];
      lg_lrb[log_idx] = lr[1];
      lg_hs2[log_idx] = hs[2];
      lg_vs2[log_idx] = vs[2];
      log_idx++;
    end
    t = en ? (t + 1) % FT : 0;
    @(negedge clk_pixel);
  endtask

  initial begin
    int cnt;
    //              t   de hs vs vb fs fnB lrB
    tbl[0]  = '{  0, 1, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{  1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{  6, 1, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{  7, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{  8, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{ 10, 0, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{ 12, 0, 1, 0, 0, 0, 0, 1};
    tbl[7]  = '{ 13, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{ 26, 0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{ 43, 0, 1, 0, 0, 0, 0, 1};
    tbl[10] = '{ 60, 0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{ 66, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{ 74, 0, 1, 0, 1, 0, 0, 0};
    tbl[13] = '{ 83, 0, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{ 96, 0, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{128, 1, 0, 0, 0, 1, 1, 0};

    rst_n = 1'b0;
    enable = 1'b0;
    pixel_valid = 1'b1;
    for (int k = 0; k < 3; k++) uf_m[k] = 1'b0;
    repeat (3) @(negedge clk_pixel);
    chk_reset_vals();

    // Release with enable already high: raster starts on the first clock.
    rst_n = 1'b1;
    log_on = 1'b1;
    for (int i = 0; i < 2 * FT; i++) cycle(1'b1, 1'b1);
    log_on = 1'b0;

    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_de", i), lg_de[tbl[i].t], tbl[i].de);
      chk($sformatf("tbl%0d_hs_lo", i), lg_hs0[tbl[i].t], !tbl[i].hs);
      chk($sformatf("tbl%0d_vs_lo", i), lg_vs0[tbl[i].t], !tbl[i].vs);
      chk($sformatf("tbl%0d_hs_hi", i), lg_hs2[tbl[i].t], tbl[i].hs);
      chk($sformatf("tbl%0d_vs_hi", i), lg_vs2[tbl[i].t], tbl[i].vs);
      chk($sformatf("tbl%0d_vblank", i), lg_vb[tbl[i].t], tbl[i].vb);
      chk($sformatf("tbl%0d_fs", i), lg_fs[tbl[i].t], tbl[i].fs);
      chk($sformatf("tbl%0d_fetch_b", i), lg_fnb[tbl[i].t], tbl[i].fnb);
      chk($sformatf("tbl%0d_lrep_b", i), lg_lrb[tbl[i].t], tbl[i].lrb);
    end
    cnt = 0;
    for (int i = 0; i < FT; i++) cnt += lg_de[i];
    chk("de_per_frame", cnt, 32);
    cnt = 0;
    for (int i = 0; i < 2 * FT; i++) cnt += lg_fs[i];
    chk("fs_per_2frames", cnt, 2);
    cnt = 0;
    for (int i = 0; i < HT; i++) cnt += lg_fnb[i];
    chk("fetch_b_per_line", cnt, 4);
    cnt = 0;
    for (int i = 0; i < FT; i++) cnt += lg_lrb[i];
    chk("lrep_b_per_frame", cnt, 6);

    // Starved fetch on line 1: sticky until the next frame_start.
    while (t != 16) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    chk("uf_set", uf[0], 1);
    while (t != 0) cycle(1'b1, 1'b1);
    chk("uf_held", uf[0], 1);
    cycle(1'b1, 1'b1);
    chk("uf_clear", uf[0], 0);
    chk("uf_clear_fs", fs[0], 1);

    // Enable dropped at hcnt 9, then re-raised.
    while (t != 9) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("endrop_de", de_o[0], 0);
    chk("endrop_x", xo[0], 0);
    chk("endrop_fs", fs[0], 0);
    cycle(1'b1, 1'b1);
    chk("reen_fetch", pre_fn[0], 1);
    chk("reen_fs", fs[0], 1);
    chk("reen_de", de_o[0], 1);

    // Asynchronous reset at hcnt 5, vcnt 2, away from any clock edge.
    while (t != 37) cycle(1'b1, 1'b1);
    chk("pre_rst_y", yo[0], 2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    t = 0;
    for (int k = 0; k < 3; k++) uf_m[k] = 1'b0;
    @(negedge clk_pixel);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1);
    chk("post_rst_x", xo[0], 0);
    chk("post_rst_y", yo[0], 0);
    chk("post_rst_fs", fs[0], 1);

    // Randomised enable and FIFO availability against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 399) != 0, $urandom_range(0, 99) < 92);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
